// File: rtl/period_fifo_fsmc_if.sv
// period_fifo_fsmc_if: capture-stage push, FSMC read bus and status signals; master = capture/ARM side, slave = FIFO
interface period_fifo_fsmc_if #(parameter int DEPTH_LOG2 = 4);
  logic [31:0] t_in;
  logic t_valid;
  logic fsmc_ne1;
  logic fsmc_noe;
  logic [2:0] addr;
  logic [15:0] rd_data;
  logic data_oe;
  logic irq;
  logic [DEPTH_LOG2:0] level;
  logic overflow;
  modport master(output t_in, t_valid, fsmc_ne1, fsmc_noe, addr, input rd_data, data_oe, irq, level, overflow);
  modport slave(input t_in, t_valid, fsmc_ne1, fsmc_noe, addr, output rd_data, data_oe, irq, level, overflow);
endinterface

// File: rtl/period_fifo_fsmc.sv
// period_fifo_fsmc: period FIFO drained over FSMC; ports clk, reset (sync, active high), bus (slave: t_in/t_valid push, ne1/noe/addr read, rd_data/data_oe/irq/level/overflow)
module period_fifo_fsmc #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH = 8
) (
  input logic clk,
  input logic reset,
  period_fifo_fsmc_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] TH = (DEPTH_LOG2+1)'(THRESH);
  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;
  state_t state, state_nx;
  logic [1:0] ne_s, noe_s;
  logic [2:0] lat, sel;
  logic [31:0] mem [DEPTH];
  logic [31:0] head;
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0] lvl;
  logic [15:0] cnt, rd_q, rd_nx;
  logic bus_rd, empty, full, pop_ok, push_ok, drop, clr, ovf, irq_q;
  assign bus_rd = ~ne_s[1] & ~noe_s[1];
  assign empty = lvl == '0;
  assign full = lvl == FULL_LVL;
  assign head = mem[rp];
  assign pop_ok = state == COMMIT && lat == 3'd1 && !empty;
  assign clr = state == COMMIT && lat == 3'd2;
  // a full FIFO still accepts a push when a pop retires the head in the same cycle
  assign push_ok = bus.t_valid & (~full | pop_ok);
  assign drop = bus.t_valid & full & ~pop_ok;
  assign sel = state == ACTIVE ? lat : bus.addr;
  assign bus.rd_data = rd_q;
  assign bus.data_oe = bus_rd;
  assign bus.irq = irq_q;
  assign bus.level = lvl;
  assign bus.overflow = ovf;
  always_comb begin
    state_nx = state == IDLE ? (bus_rd ? ACTIVE : IDLE) : state == ACTIVE ? (bus_rd ? ACTIVE : COMMIT) : IDLE;
    rd_nx = sel == 3'd0 ? (empty ? 16'h0 : head[15:0]) :
            sel == 3'd1 ? (empty ? 16'h0 : head[31:16]) :
            sel == 3'd2 ? {ovf, empty, 14'(lvl)} :
            sel == 3'd3 ? cnt : 16'h0;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= bus.t_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      ne_s <= 2'b11;
      noe_s <= 2'b11;
      lat <= '0;
      wp <= '0;
      rp <= '0;
      lvl <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      irq_q <= 1'b0;
      rd_q <= '0;
    end else begin
      ne_s <= {ne_s[0], bus.fsmc_ne1};
      noe_s <= {noe_s[0], bus.fsmc_noe};
      if (state == IDLE && bus_rd) lat <= bus.addr;
      if (push_ok) wp <= wp + DEPTH_LOG2'(1);
      if (pop_ok) rp <= rp + DEPTH_LOG2'(1);
      lvl <= lvl + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
      cnt <= cnt + 16'(bus.t_valid);
      ovf <= drop | (ovf & ~clr);
      irq_q <= lvl >= TH;
      rd_q <= rd_nx;
    end
  end
endmodule

// File: tb/tb_period_fifo_fsmc.sv
// tb_period_fifo_fsmc: scoreboard bench for period_fifo_fsmc; reads queue expectations, a monitor checks them as each access ends
module tb_period_fifo_fsmc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  period_fifo_fsmc_if #(.DEPTH_LOG2(4)) bus();
  period_fifo_fsmc #(.DEPTH_LOG2(4), .THRESH(8)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic [2:0] a; logic [15:0] d;} exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  bit abort = 1'b0;
  bit prev_oe = 1'b0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(logic [31:0] v);
    @(negedge clk);
    bus.t_in = v;
    bus.t_valid = 1'b1;
    @(negedge clk);
    bus.t_valid = 1'b0;
  endtask
  task automatic rd_start(logic [2:0] a, logic [15:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
    bus.addr = a;
    tick(1);
    bus.fsmc_ne1 = 1'b0;
    bus.fsmc_noe = 1'b0;
    tick(6);
    bus.fsmc_ne1 = 1'b1;
    bus.fsmc_noe = 1'b1;
  endtask
  task automatic rd(logic [2:0] a, logic [15:0] d);
    rd_start(a, d);
    tick(6);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.t_valid = 1'b0;
    bus.fsmc_ne1 = 1'b1;
    bus.fsmc_noe = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (prev_oe && !bus.data_oe) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (bus.rd_data === e.d) passed++;
        else $display("FAIL rd_addr%0d: got %h want %h", e.a, bus.rd_data, e.d);
      end else if (!abort) begin
        checks++;
        $display("FAIL unexpected_read: got %h want none", bus.rd_data);
      end
    end
    prev_oe = bus.data_oe;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    bus.t_in = '0;
    bus.t_valid = 1'b0;
    bus.fsmc_ne1 = 1'b1;
    bus.fsmc_noe = 1'b1;
    bus.addr = 3'd0;
    tick(2);
    reset = 1'b0;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_oe", 32'(bus.data_oe), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_rd", 32'(bus.rd_data), 0);
    rd(3'd2, 16'h4000);
    push(32'h12345678);
    chk("push1_level", 32'(bus.level), 1);
    rd(3'd0, 16'h5678);
    rd(3'd1, 16'h1234);
    chk("pop_level", 32'(bus.level), 0);
    rd(3'd1, 16'h0000);
    chk("empty_pop_level", 32'(bus.level), 0);
    for (int i = 0; i < 8; i++) push(32'hA000_0000 | 32'(i));
    chk("irq_lag", 32'(bus.irq), 0);
    chk("level8", 32'(bus.level), 8);
    tick(1);
    chk("irq_rise", 32'(bus.irq), 1);
    rd(3'd1, 16'hA000);
    chk("level7", 32'(bus.level), 7);
    chk("irq_fall", 32'(bus.irq), 0);
    do_reset();
    for (int i = 0; i < 17; i++) push({16'(i + 256), 16'(i)});
    chk("full_level", 32'(bus.level), 16);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("full_irq", 32'(bus.irq), 1);
    rd(3'd2, 16'h8010);
    rd(3'd3, 16'h0011);
    rd(3'd2, 16'h0010);
    rd(3'd5, 16'h0000);
    chk("ovf_clr", 32'(bus.overflow), 0);
    rd_start(3'd1, 16'h0100);
    tick(3);
    chk("in_commit", 32'(dut.state), 2);
    bus.t_in = 32'hCAFEF00D;
    bus.t_valid = 1'b1;
    tick(1);
    bus.t_valid = 1'b0;
    chk("full_swap_level", 32'(bus.level), 16);
    chk("full_swap_ovf", 32'(bus.overflow), 0);
    tick(6);
    for (int i = 1; i < 16; i++) rd(3'd1, 16'(i + 256));
    rd(3'd0, 16'hF00D);
    rd(3'd1, 16'hCAFE);
    chk("drain_level", 32'(bus.level), 0);
    chk("drain_irq", 32'(bus.irq), 0);
    do_reset();
    push(32'h55AA33CC);
    bus.addr = 3'd1;
    tick(1);
    bus.fsmc_ne1 = 1'b0;
    bus.fsmc_noe = 1'b0;
    for (int n = 0; n < 10 && dut.state != 1; n++) tick(1);
    chk("reach_active", 32'(dut.state), 1);
    tick(1);
    abort = 1'b1;
    reset = 1'b1;
    bus.fsmc_ne1 = 1'b1;
    bus.fsmc_noe = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_rd", 32'(bus.rd_data), 0);
    chk("abort_oe", 32'(bus.data_oe), 0);
    chk("abort_irq", 32'(bus.irq), 0);
    chk("abort_level", 32'(bus.level), 0);
    chk("abort_ovf", 32'(bus.overflow), 0);
    chk("abort_state", 32'(dut.state), 0);
    tick(8);
    chk("abort_state_later", 32'(dut.state), 0);
    chk("abort_level_later", 32'(bus.level), 0);
    abort = 1'b0;
    push(32'h0000_0001);
    rd(3'd0, 16'h0001);
    tick(4);
    chk("sb_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
